// File: rtl/rv_pkg.sv
// Shared writeback types: register addresses, write requests, winner tags and
// the scoreboard helper used by the regfile writeback scheduler.
package rv_pkg;

    localparam int RV_XLEN = 32;

    typedef logic [4:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

    typedef struct packed {
        reg_addr_t          addr;
        logic [RV_XLEN-1:0] data;
    } wb_req_t;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_EX,
        WB_LD
    } wb_src_e;

    // x0 is never outstanding, so it can never cause a stall.
    function automatic logic reg_busy(input reg_addr_t a, input logic [31:0] pend);
        return (a != REG_ZERO) && pend[a];
    endfunction

endpackage

// File: rtl/u_rf_scoreboard.sv
// Outstanding-load scoreboard: one pend bit per register, set by an issuing
// load, cleared by its return, and the decode-stage RAW/WAW hazard compare.
module u_rf_scoreboard
    import rv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        set_en,
    input  reg_addr_t   set_a,
    input  logic        clr_en,
    input  reg_addr_t   clr_a,
    input  reg_addr_t   rs1_a,
    input  reg_addr_t   rs2_a,
    input  reg_addr_t   dec_rd_a,
    output logic        hazard,
    output logic [31:0] pend
);

    localparam logic [31:0] X0_MASK = 32'h0000_0001;

    logic [31:0] set_mask;
    logic [31:0] clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en && (set_a != REG_ZERO)) set_mask[set_a] = 1'b1;
        if (clr_en)                         clr_mask[clr_a] = 1'b1;
    end

    // Clear first, then OR the set in: a reissue of the returning register stays pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            pend <= ((pend & ~clr_mask) | set_mask) & ~X0_MASK;
        end
    end

    assign hazard = reg_busy(rs1_a, pend)
                  | reg_busy(rs2_a, pend)
                  | reg_busy(dec_rd_a, pend);

endmodule

// File: rtl/u_rf_wb_arb.sv
// Writeback scheduler for the single regfile write port: arbitrates execute
// results against load returns with starvation relief, registers the write.
module u_rf_wb_arb
    import rv_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int XLEN       = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [4:0]      ex_rd_a,
    input  logic [XLEN-1:0] ex_rd_i,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [4:0]      ld_rd_a,
    input  logic [XLEN-1:0] ld_rd_i,
    input  logic            ld_issue,
    input  logic [4:0]      ld_issue_rd_a,
    input  logic [4:0]      rs1_a,
    input  logic [4:0]      rs2_a,
    input  logic [4:0]      dec_rd_a,
    output logic            hazard_o,
    output logic [31:0]     pend_o,
    output logic            rd_e,
    output logic [4:0]      rd_a,
    output logic [XLEN-1:0] rd_i
);

    if (XLEN != RV_XLEN) begin : g_bad_xlen
        $error("u_rf_wb_arb: XLEN must equal rv_pkg::RV_XLEN");
    end

    localparam int CW = 4;

    logic [CW-1:0] starve_cnt;
    logic          starve_hit;
    logic          ld_wins;
    logic          grant;
    logic          wr_en;
    wb_req_t       win_req;
    wb_src_e       wb_src_q;

    // Handshake: a transfer happens on an edge where valid & ready are both high.
    // Ready is a same-cycle combinational grant and never rises without valid;
    // the source must hold valid and payload stable until it sees ready.
    assign starve_hit = (starve_cnt == CW'(STARVE_MAX));
    assign ld_wins    = ld_valid & ~(ex_valid & starve_hit);
    assign ld_ready   = ld_valid & ld_wins;
    assign ex_ready   = ex_valid & ~ld_wins;
    assign grant      = ex_ready | ld_ready;

    always_comb begin
        win_req = '{addr: ex_rd_a, data: ex_rd_i};
        if (ld_ready) win_req = '{addr: ld_rd_a, data: ld_rd_i};
    end

    // A granted x0 write still completes the handshake but never reaches the regfile.
    assign wr_en = grant & (win_req.addr != REG_ZERO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (ex_valid & ld_ready) begin
            if (!starve_hit) starve_cnt <= starve_cnt + 1'b1;
        end else begin
            starve_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_e     <= 1'b0;
            rd_a     <= REG_ZERO;
            rd_i     <= '0;
            wb_src_q <= WB_NONE;
        end else begin
            rd_e <= wr_en;
            if (wr_en) begin
                rd_a <= win_req.addr;
                rd_i <= win_req.data;
            end
            if (ld_ready)      wb_src_q <= WB_LD;
            else if (ex_ready) wb_src_q <= WB_EX;
            else               wb_src_q <= WB_NONE;
        end
    end

    u_rf_scoreboard u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (ld_issue),
        .set_a    (ld_issue_rd_a),
        .clr_en   (ld_ready),
        .clr_a    (ld_rd_a),
        .rs1_a    (rs1_a),
        .rs2_a    (rs2_a),
        .dec_rd_a (dec_rd_a),
        .hazard   (hazard_o),
        .pend     (pend_o)
    );

    a_issue_no_hazard: assert property (@(posedge clk) disable iff (!rst_n)
        !(ld_issue && hazard_o));

    a_ld_ret_pending: assert property (@(posedge clk) disable iff (!rst_n)
        (ld_valid && (ld_rd_a != REG_ZERO)) |-> pend_o[ld_rd_a]);

    a_ex_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (ex_valid && !ex_ready) |=> (ex_valid && $stable(ex_rd_a) && $stable(ex_rd_i)));

    a_ld_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (ld_valid && !ld_ready) |=> (ld_valid && $stable(ld_rd_a) && $stable(ld_rd_i)));

    a_wr_has_src: assert property (@(posedge clk) disable iff (!rst_n)
        rd_e |-> (wb_src_q != WB_NONE));

endmodule

// File: tb/tb_u_rf_wb_arb.sv
// Bench for u_rf_wb_arb: directed scenarios then random traffic, checked
// against a cycle-level reference model and a timestamped write queue.
module tb_u_rf_wb_arb;

    localparam int SM   = 4;
    localparam int XLEN = 32;
    localparam int EW   = 32 + 5 + XLEN;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            ex_valid, ex_ready;
    logic [4:0]      ex_rd_a;
    logic [XLEN-1:0] ex_rd_i;
    logic            ld_valid, ld_ready;
    logic [4:0]      ld_rd_a;
    logic [XLEN-1:0] ld_rd_i;
    logic            ld_issue;
    logic [4:0]      ld_issue_rd_a;
    logic [4:0]      rs1_a, rs2_a, dec_rd_a;
    logic            hazard_o;
    logic [31:0]     pend_o;
    logic            rd_e;
    logic [4:0]      rd_a;
    logic [XLEN-1:0] rd_i;

    u_rf_wb_arb #(.STARVE_MAX(SM), .XLEN(XLEN)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_rd_a       (ex_rd_a),
        .ex_rd_i       (ex_rd_i),
        .ld_valid      (ld_valid),
        .ld_ready      (ld_ready),
        .ld_rd_a       (ld_rd_a),
        .ld_rd_i       (ld_rd_i),
        .ld_issue      (ld_issue),
        .ld_issue_rd_a (ld_issue_rd_a),
        .rs1_a         (rs1_a),
        .rs2_a         (rs2_a),
        .dec_rd_a      (dec_rd_a),
        .hazard_o      (hazard_o),
        .pend_o        (pend_o),
        .rd_e          (rd_e),
        .rd_a          (rd_a),
        .rd_i          (rd_i)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected writes: {edge cycle number, address, data}
    logic [EW-1:0] exp_q[$];

    // Stimulus state and reference model
    logic            s_ex_v, s_ld_v, s_issue;
    logic [4:0]      s_ex_a, s_ld_a, s_issue_a, s_rs1, s_rs2, s_dec;
    logic [XLEN-1:0] s_ex_d, s_ld_d;
    logic [31:0]     m_pend;
    int              m_lose;
    logic            g_ex_acc, g_ld_acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic m_busy(input logic [4:0] a);
        return (a != 5'd0) && m_pend[a];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle_stim();
        s_ex_v = 0; s_ex_a = 0; s_ex_d = 0;
        s_ld_v = 0; s_ld_a = 0; s_ld_d = 0;
        s_issue = 0; s_issue_a = 0;
        s_rs1 = 0; s_rs2 = 0; s_dec = 0;
    endtask

    task automatic apply();
        ex_valid = s_ex_v; ex_rd_a = s_ex_a; ex_rd_i = s_ex_d;
        ld_valid = s_ld_v; ld_rd_a = s_ld_a; ld_rd_i = s_ld_d;
        ld_issue = s_issue; ld_issue_rd_a = s_issue_a;
        rs1_a = s_rs1; rs2_a = s_rs2; dec_rd_a = s_dec;
    endtask

    // One clock cycle: drive, check combinational outputs, predict the edge.
    task automatic cycle();
        logic ldw, exr, haz;
        @(posedge clk);
        #1;
        apply();
        #1;
        ldw = s_ld_v && !(s_ex_v && (m_lose == SM));
        exr = s_ex_v && !ldw;
        haz = m_busy(s_rs1) || m_busy(s_rs2) || m_busy(s_dec);
        chk("ex_ready", 32'(ex_ready), 32'(exr));
        chk("ld_ready", 32'(ld_ready), 32'(ldw));
        chk("hazard_o", 32'(hazard_o), 32'(haz));
        chk("pend_o", pend_o, m_pend);
        g_ex_acc = exr;
        g_ld_acc = ldw;
        if (exr && s_ex_a != 0) exp_q.push_back({32'(cyc + 1), s_ex_a, s_ex_d});
        if (ldw && s_ld_a != 0) exp_q.push_back({32'(cyc + 1), s_ld_a, s_ld_d});
        if (s_ex_v && s_ld_v && ldw) m_lose = (m_lose < SM) ? m_lose + 1 : SM;
        else                         m_lose = 0;
        if (ldw) m_pend[s_ld_a] = 1'b0;
        if (s_issue && s_issue_a != 0) m_pend[s_issue_a] = 1'b1;
        m_pend[0] = 1'b0;
    endtask

    task automatic issue(input logic [4:0] a);
        s_issue = 1; s_issue_a = a;
        cycle();
        s_issue = 0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [EW-1:0] e;
        logic [31:0]   e_cyc;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (rd_e) begin
                    if (exp_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL wr_unexpected: got write x%0d=0x%08h expected no write (cycle %0d)", rd_a, rd_i, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_cycle", 32'(cyc), e[EW-1 -: 32]);
                        chk("wr_addr", 32'(rd_a), 32'(e[XLEN+4 -: 5]));
                        chk("wr_data", rd_i, e[XLEN-1:0]);
                    end
                end else if (exp_q.size() != 0) begin
                    e = exp_q[0];
                    e_cyc = e[EW-1 -: 32];
                    if (e_cyc == 32'(cyc)) begin
                        n_checks++; n_fail++;
                        $display("FAIL wr_missing: got rd_e=0 expected write x%0d (cycle %0d)", e[XLEN+4 -: 5], cyc);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test expected finish within 2 ms");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int nxt;
        int first_ex;
        int cand[$];
        logic haz;

        idle_stim();
        apply();
        m_pend = '0; m_lose = 0; g_ex_acc = 0; g_ld_acc = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_e", 32'(rd_e), 32'd0);
        chk("rst_rd_a", 32'(rd_a), 32'd0);
        chk("rst_rd_i", rd_i, 32'd0);
        chk("rst_pend", pend_o, 32'd0);
        #2 rst_n = 1'b1;

        // Simple ex write to x3
        s_ex_v = 1; s_ex_a = 3; s_ex_d = 32'h0000_0011;
        cycle();
        s_ex_v = 0;
        cycle();
        cycle();

        // Load scoreboard on x7
        issue(5'd7);
        s_rs1 = 7;
        cycle();
        s_ld_v = 1; s_ld_a = 7; s_ld_d = 32'h0000_1234;
        cycle();
        s_ld_v = 0;
        cycle();
        s_rs1 = 0;
        cycle();

        // Starvation: ex on x1 held against back-to-back loads
        for (int r = 10; r <= 15; r++) issue(5'(r));
        nxt = 10; first_ex = -1;
        s_ex_v = 1; s_ex_a = 1; s_ex_d = $urandom;
        s_ld_v = 1; s_ld_a = 5'(nxt); s_ld_d = $urandom;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (g_ex_acc && first_ex < 0) first_ex = i;
            if (g_ex_acc) s_ex_d = $urandom;
            if (g_ld_acc) begin
                nxt++;
                s_ld_v = (nxt <= 15);
                s_ld_a = 5'(nxt);
                s_ld_d = $urandom;
            end
        end
        chk("starve_ex_slot", 32'(first_ex), 32'(SM));
        s_ex_v = 0; s_ld_v = 0;
        cycle();

        // Set/clear collision on x9
        issue(5'd9);
        s_ld_v = 1; s_ld_a = 9; s_ld_d = $urandom;
        s_issue = 1; s_issue_a = 9;
        cycle();
        s_ld_v = 0; s_issue = 0;
        cycle();
        chk("pend9_kept", 32'(pend_o[9]), 32'd1);
        cycle();

        // x0 handling
        s_ex_v = 1; s_ex_a = 0; s_ex_d = $urandom;
        cycle();
        s_ex_v = 0; s_issue = 1; s_issue_a = 0;
        cycle();
        s_issue = 0;
        cycle();
        cycle();

        // Reset in the middle of a granted load to x5
        issue(5'd5);
        s_ld_v = 1; s_ld_a = 5; s_ld_d = 32'hDEAD_BEEF;
        cycle();
        #1;
        rst_n = 1'b0;
        idle_stim();
        apply();
        #1;
        chk("midrst_rd_e", 32'(rd_e), 32'd0);
        chk("midrst_pend", pend_o, 32'd0);
        if (g_ld_acc) void'(exp_q.pop_back());
        m_pend = '0; m_lose = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("postrst_rd_e", 32'(rd_e), 32'd0);
        end

        // Random traffic
        g_ex_acc = 0; g_ld_acc = 0;
        for (int i = 0; i < 1500; i++) begin
            if (!s_ex_v || g_ex_acc) begin
                s_ex_v = ($urandom_range(0, 99) < 55);
                s_ex_a = 5'($urandom_range(0, 31));
                s_ex_d = $urandom;
            end
            if (!s_ld_v || g_ld_acc) begin
                cand.delete();
                for (int r = 1; r < 32; r++) if (m_pend[r]) cand.push_back(r);
                s_ld_v = (cand.size() > 0) && ($urandom_range(0, 99) < 70);
                if (s_ld_v) s_ld_a = 5'(cand[$urandom_range(0, cand.size() - 1)]);
                s_ld_d = $urandom;
            end
            s_rs1 = 5'($urandom_range(0, 31));
            s_rs2 = 5'($urandom_range(0, 31));
            s_dec = 5'($urandom_range(0, 31));
            haz = m_busy(s_rs1) || m_busy(s_rs2) || m_busy(s_dec);
            s_issue   = !haz && ($urandom_range(0, 99) < 40);
            s_issue_a = 5'($urandom_range(0, 31));
            cycle();
        end

        // Drain held requests, then go idle
        s_issue = 0; s_rs1 = 0; s_rs2 = 0; s_dec = 0;
        for (int k = 0; k < 40 && (s_ex_v || s_ld_v); k++) begin
            if (g_ex_acc) s_ex_v = 0;
            if (g_ld_acc) s_ld_v = 0;
            if (s_ex_v || s_ld_v) cycle();
        end
        s_ex_v = 0; s_ld_v = 0;
        cycle();
        cycle();
        @(negedge clk);
        #1;
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/u_rf_wb_arb.md
Name: u_rf_wb_arb

Overview:
Writeback scheduler for the single register-file write port. It arbitrates between the execute-stage result (ex) and the load-return path (ld), and drives registered rd_e/rd_a/rd_i into the regfile. It also keeps a scoreboard of registers with outstanding loads and raises a decode-stage hazard (stall) on RAW/WAW against them. It sits between EX/LSU and the regfile, beside decode.

Parameters:
STARVE_MAX, 4, consecutive cycles ex may lose to ld before ex is forced to win one grant (1..15)
XLEN, 32, data width of write port

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
ex_valid  input  1  execute result valid
ex_ready  output  1  execute result accepted this cycle
ex_rd_a  input  5  execute destination
ex_rd_i  input  XLEN  execute data
ld_valid  input  1  load return valid
ld_ready  output  1  load return accepted this cycle
ld_rd_a  input  5  load destination
ld_rd_i  input  XLEN  load data
ld_issue  input  1  load leaving decode (marks destination pending)
ld_issue_rd_a  input  5  destination of issuing load
rs1_a  input  5  decode source 1
rs2_a  input  5  decode source 2
dec_rd_a  input  5  decode destination
hazard_o  output  1  decode must stall
pend_o  output  32  scoreboard bit vector (debug/verification)
rd_e  output  1  regfile write enable
rd_a  output  5  regfile write address
rd_i  output  XLEN  regfile write data

Behaviour:
- Reset (async, rst_n=0): rd_e=0, rd_a=0, rd_i=0, pend all 0, starve counter 0. Takes effect immediately, mid-transfer included. In-flight grants are dropped.
- Grant (combinational, every cycle):
  - Default priority is ld over ex.
  - If starve_cnt==STARVE_MAX and ex_valid, ex wins.
  - ld_ready = ld_valid & ld_wins; ex_ready = ex_valid & ~ld_wins.
  - At most one ready high per cycle; a ready is never high without its valid.
- Starve counter:
  - Increments when ex_valid & ld_valid & ld granted.
  - Clears when ex is granted or ex_valid=0.
  - Saturates at STARVE_MAX.
- Write port (registered, latency 1):
  - On the edge after a grant: rd_e=1, rd_a/rd_i = winner's address/data.
  - Otherwise rd_e=0; rd_a/rd_i hold their previous values.
  - A granted write to x0 completes the handshake, but rd_e stays 0.
- Scoreboard:
  - pend[ld_issue_rd_a] is set on an edge with ld_issue & ld_issue_rd_a!=0.
  - pend[ld_rd_a] is cleared on the edge where ld is granted, so it clears in the same cycle rd_e rises. The regfile bypass covers the read in that cycle.
  - Same register set and cleared on the same edge: set wins.
  - Set and clear of different registers on the same edge: both apply.
  - pend[0] is always 0.
- Hazard (combinational): hazard_o = (rs1_a!=0 & pend[rs1_a]) | (rs2_a!=0 & pend[rs2_a]) | (dec_rd_a!=0 & pend[dec_rd_a]).
  - The dec_rd_a term stops ex writeback from overtaking an outstanding load (WAW).
- Illegal stimulus, flagged by simulation-only assertions:
  - ld_issue while hazard_o=1.
  - ld_valid with pend[ld_rd_a]=0 and ld_rd_a!=0.
  - Valid dropped or payload changed while valid & ~ready.

Decomposition:
- Shared package (rv_pkg) holds:
  - typedef reg_addr_t (logic [4:0]).
  - typedef wb_req_t {addr, data}.
  - typedef enum wb_src_e {WB_NONE, WB_EX, WB_LD} for the registered winner (debug).
  - constant REG_ZERO.
- Sub-module u_rf_scoreboard: pend vector, set/clear with set priority, and the three-way hazard compare.
- Arbiter, starve counter and write-port register stay in the top.

Test Plan:
- Reset mid-transfer: ld granted (x5, 0xDEAD_BEEF), rst_n low before the edge → rd_e=0, pend=0 immediately; after release, no write appears.
- Simple ex write: ex_valid, x3=0x0000_0011 → ex_ready same cycle, rd_e=1 rd_a=3 rd_i=0x11 the next cycle, rd_e=0 the cycle after.
- Load scoreboard: ld_issue x7; next cycle rs1_a=7 → hazard_o=1. ld returns x7=0x1234 → on the grant edge pend[7]=0, rd_e=1 rd_a=7, hazard_o=0 in that cycle.
- Contention/starvation, STARVE_MAX=4: ex (x1) and ld (x2) both held valid with ld back-to-back → ld wins 4 cycles, ex wins the 5th, counter back to 0, ld resumes.
- Set/clear collision: ld returns x9 while ld_issue x9 on the same edge → write to x9 occurs and pend[9] stays 1.
- x0 handling: ex write to x0 → ex_ready=1, rd_e stays 0. ld_issue x0 → pend unchanged, hazard_o=0 with rs1_a=0.
